alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked ALU for the datapath: WIDTH-bit operands, a 4-bit opcode, registered result plus status flags, and valid/ready flow control on both sides. Single-cycle ops complete with one cycle of latency. An optional iterative shift-add multiplier takes WIDTH cycles. The block replaces ad-hoc combinational ALUs wherever a producer/consumer pipeline stage is needed.

## Interface
- WIDTH, 8, operand/result width; power of two, 4..64
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid_i  in  1  operand/opcode valid
- in_ready_o  out  1  block can accept an operation this cycle
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B; shifts use b_i[SHW-1:0]
- op_i  in  4  opcode
- out_valid_o  out  1  result/flags valid
- out_ready_i  in  1  consumer takes the result
- alu_o  out  WIDTH  result
- flags_o  out  4  {n, z, c, v}
- err_o  out  1  illegal opcode for this result

## Operation
- Opcodes:
  - 0 ADD; 1 SUB (a−b); 2 SLL; 3 SRL (logical); 4 AND; 5 OR; 6 XOR
  - 7 EQL (alu_o = {0…, a==b})
  - 8 SRA (arithmetic); 9 SLT (signed a<b, 0/1); 10 SLTU (unsigned a<b, 0/1)
  - 11 MUL (low WIDTH bits of a×b, unsigned)
  - 12–15 illegal
- Flags, computed on the final alu_o:
  - z = (alu_o==0); n = alu_o[WIDTH-1]
  - c: ADD = carry out; SUB = carry out of a+~b+1 (1 when a≥b unsigned); MUL = 1 if upper product half ≠0; otherwise 0
  - v: ADD/SUB = two's-complement overflow; otherwise 0
- Illegal opcode: alu_o=0, flags_o=4'b0100 (z=1), err_o=1; completes like a single-cycle op. err_o=0 for every legal op.
- Acceptance: an operation is accepted on any rising edge with in_valid_i && in_ready_o. a_i, b_i and op_i are sampled only at that edge.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). This is full-throughput pass-through when the consumer is ready.
- Output register: holds alu_o/flags_o/err_o stable while out_valid_o && !out_ready_i. It is cleared when the result is taken and no new result is loaded.
- State machine:
  - IDLE: accepting a single-cycle op loads the output register at the same edge. Accepting MUL goes to MUL, loads the multiplicand = a, multiplier = b, acc = 0 and count = 0.
  - MUL: each edge, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count reaches WIDTH−1 the output register loads the final acc and flags, and the state returns to IDLE.
  - If the previous result is still pending at that edge, the state stalls in MUL at the final count until out_ready_i.
- Reset (async, any time including mid-MUL): state=IDLE, out_valid_o=0, alu_o=0, flags_o=0, err_o=0, internal multiply registers=0. in_ready_o=1 one combinational settle after reset release.

## Timing
- Single-cycle ops: accepted at edge k → out_valid_o=1 and result valid after edge k. Back-to-back accepts every cycle while out_ready_i=1.
- MUL: accepted at edge k → out_valid_o=1 after edge k+WIDTH. in_ready_o=0 during cycles k+1..k+WIDTH.
- Simultaneous take + accept at the same edge: the new result replaces the old one, and out_valid_o stays 1.
- in_valid_i deasserted with no pending result: out_valid_o falls after the edge where the result is taken.
- Shifts by 0 return a unchanged. Shift amounts use only the low SHW bits of b_i.

## Configuration
- ALU_PIPE_MUL_EN defined: opcode 11 executes the iterative multiplier as above.
- ALU_PIPE_MUL_EN undefined: opcode 11 is treated as illegal (err_o=1, single-cycle). The MUL state and multiply registers are not instantiated, so the FSM is IDLE only.

## Test plan
- Reset mid-MUL: assert reset_n=0 during MUL → out_valid_o=0 and alu_o=0 immediately; after release, ADD 3+4 → alu_o=7.
- WIDTH=8, ADD 0xFF+0x01 → alu_o=0x00, flags n=0 z=1 c=1 v=0. ADD 0x7F+0x01 → 0x80, n=1 v=1.
- SUB/compare:
  - SUB 0x05−0x07 → 0xFE, c=0, n=1
  - SLT 0x80,0x01 → 1; SLTU 0x80,0x01 → 0
  - SRA 0x80 by 3 → 0xF0; SRL 0x80 by 3 → 0x10
- Back-pressure: issue ADD 1+1 and hold out_ready_i=0 for 5 cycles → alu_o=2 held and in_ready_o=0. Then stream 4 ops with out_ready_i=1 → 1 result per cycle, in order.
- MUL (macro on), 0x0F×0x11 → alu_o=0xFF, c=0, out_valid_o exactly 8 cycles after acceptance. 0x10×0x10 → alu_o=0x00, z=1, c=1.
- Illegal op 13, and op 11 with the macro off → alu_o=0, flags_o=4'b0100, err_o=1, latency 1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready handshaked WIDTH-bit ALU with a registered result and {n,z,c,v} flags.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for opcode 11.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] alu_o,
  output logic [3:0]       flags_o,
  output logic             err_o,
  output logic             dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_EQL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             err;
  } result_t;

  state_t           state_q;
  result_t          sc_r;
  result_t          out_d;
  result_t          out_q;
  logic             out_valid_q;
  logic             can_load;
  logic             accept;
  logic             load_out;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_err;

  // Handshake: a transfer happens on a rising edge where valid && ready. The producer
  // holds a_i/b_i/op_i while in_valid_i is high and ready is low; the output register
  // holds its contents while out_valid_o is high and out_ready_i is low.
  assign can_load   = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == S_IDLE) && can_load;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    sh     = b_i[SHW-1:0];
    sum    = {1'b0, a_i} + {1'b0, b_i};
    diff   = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op_i)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLL:  sc_res = a_i << sh;
      OP_SRL:  sc_res = a_i >> sh;
      OP_AND:  sc_res = a_i & b_i;
      OP_OR:   sc_res = a_i | b_i;
      OP_XOR:  sc_res = a_i ^ b_i;
      OP_EQL:  sc_res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_SRA:  sc_res = $unsigned($signed(a_i) >>> sh);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      // Opcode 11 also lands here; with the multiplier built this path is never loaded for it.
      default: sc_err = 1'b1;
    endcase
    sc_r.res   = sc_res;
    sc_r.flags = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
    sc_r.err   = sc_err;
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;

  state_t             state_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     count_q;
  logic               mul_last;
  logic               mul_step;
  logic               mul_done;
  logic               mul_start;
  result_t            mul_r;

  assign mul_start = accept && (op_i == OP_MUL);
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign mul_last  = (count_q == SHW'(WIDTH-1));

  always_comb begin
    mul_r.res   = acc_next[WIDTH-1:0];
    mul_r.flags = {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0),
                   (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
    mul_r.err   = 1'b0;
  end

  // The last partial product is folded in on the same edge the result is stored,
  // so a pending result stalls the final step rather than finishing early.
  always_comb begin
    state_d  = state_q;
    mul_step = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL: begin
        if (!mul_last) begin
          mul_step = 1'b1;
        end else if (can_load) begin
          mul_step = 1'b1;
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mcand_q  <= {{WIDTH{1'b0}}, a_i};
        mplier_q <= b_i;
        acc_q    <= '0;
        count_q  <= '0;
      end else if (mul_step) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + SHW'(1);
      end
    end
  end

  assign load_out = (accept && !mul_start) || mul_done;
  assign out_d    = mul_done ? mul_r : sc_r;
`else
  assign state_q  = S_IDLE;
  assign load_out = accept;
  assign out_d    = sc_r;
`endif

  assign dbg_state_o = (state_q == S_MUL);

  // A taken result with nothing new behind it clears the register, not just the valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_q       <= out_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign alu_o       = out_q.res;
  assign flags_o     = out_q.flags;
  assign err_o       = out_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8); the multiplier scenarios build only with ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  localparam int W = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_EQL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  logic         clk;
  logic         reset_n;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [3:0]   op_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] alu_o;
  logic [3:0]   flags_o;
  logic         err_o;
  logic         dbg_state_o;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_o       (alu_o),
    .flags_o     (flags_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    op_i       = op;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    a_i         = '0;
    b_i         = '0;
    op_i        = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid_o, alu_o, flags_o, err_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b alu=%h flags=%b err=%b state=%b, required all 0",
               out_valid_o, alu_o, flags_o, err_o, dbg_state_o);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready_o);
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready_i = 1'b0;
    drive(8'h09, 8'h09, OP_ADD);
    @(negedge clk);
    idle();
    n_checks++;
    if ({out_valid_o, alu_o} !== {1'b1, 8'h12}) begin
      n_fail++;
      $display("FAIL pend_before_reset: valid=%b alu=%h, required 1 12", out_valid_o, alu_o);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, alu_o, flags_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_pending: valid=%b alu=%h flags=%b err=%b, required all 0",
               out_valid_o, alu_o, flags_o, err_o);
    end
    @(negedge clk);
    reset_n     = 1'b1;
    out_ready_i = 1'b1;
    #1;
`ifdef ALU_PIPE_MUL_EN
    drive(8'h03, 8'h05, OP_MUL);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dbg_state_o, in_ready_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_mul_busy: state=%b in_ready=%b, required 1 0", dbg_state_o, in_ready_o);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, alu_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_mid_mul: valid=%b alu=%h state=%b, required 0 00 0",
               out_valid_o, alu_o, dbg_state_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_mul_reset: in_ready=%b, required 1", in_ready_o);
    end
`endif
    drive(8'h03, 8'h04, OP_ADD);
    @(negedge clk);
    idle();
    n_checks++;
    if ({out_valid_o, alu_o, flags_o, err_o} !== {1'b1, 8'h07, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL add_after_reset: valid=%b alu=%h flags=%b err=%b, required 1 07 0000 0",
               out_valid_o, alu_o, flags_o, err_o);
    end
  endtask

  // Streams one op per cycle; each result is checked one edge after its acceptance.
  task automatic test_alu_ops();
    vec_t v[$];
    v.push_back('{8'hFF, 8'h01, OP_ADD,  8'h00, 4'b0110});
    v.push_back('{8'h7F, 8'h01, OP_ADD,  8'h80, 4'b1001});
    v.push_back('{8'h12, 8'h34, OP_ADD,  8'h46, 4'b0000});
    v.push_back('{8'h05, 8'h07, OP_SUB,  8'hFE, 4'b1000});
    v.push_back('{8'h07, 8'h05, OP_SUB,  8'h02, 4'b0010});
    v.push_back('{8'h80, 8'h01, OP_SUB,  8'h7F, 4'b0011});
    v.push_back('{8'h33, 8'h33, OP_SUB,  8'h00, 4'b0110});
    v.push_back('{8'h01, 8'h0B, OP_SLL,  8'h08, 4'b0000});
    v.push_back('{8'h81, 8'h01, OP_SLL,  8'h02, 4'b0000});
    v.push_back('{8'h80, 8'h03, OP_SRL,  8'h10, 4'b0000});
    v.push_back('{8'hA5, 8'h08, OP_SRL,  8'hA5, 4'b1000});
    v.push_back('{8'h80, 8'h03, OP_SRA,  8'hF0, 4'b1000});
    v.push_back('{8'h40, 8'h02, OP_SRA,  8'h10, 4'b0000});
    v.push_back('{8'hF0, 8'h3C, OP_AND,  8'h30, 4'b0000});
    v.push_back('{8'hF0, 8'h0F, OP_OR,   8'hFF, 4'b1000});
    v.push_back('{8'hAA, 8'hAA, OP_XOR,  8'h00, 4'b0100});
    v.push_back('{8'h05, 8'h05, OP_EQL,  8'h01, 4'b0000});
    v.push_back('{8'h05, 8'h06, OP_EQL,  8'h00, 4'b0100});
    v.push_back('{8'h80, 8'h01, OP_SLT,  8'h01, 4'b0000});
    v.push_back('{8'h01, 8'h80, OP_SLT,  8'h00, 4'b0100});
    v.push_back('{8'h80, 8'h01, OP_SLTU, 8'h00, 4'b0100});
    v.push_back('{8'h01, 8'h80, OP_SLTU, 8'h01, 4'b0000});
    out_ready_i = 1'b1;
    for (int i = 0; i <= v.size(); i++) begin
      if (i > 0) begin
        n_checks++;
        if ({out_valid_o, in_ready_o, alu_o, flags_o, err_o} !==
            {1'b1, 1'b1, v[i-1].r, v[i-1].f, 1'b0}) begin
          n_fail++;
          $display("FAIL op_vec%0d (op=%0d a=%h b=%h): valid=%b ready=%b alu=%h flags=%b err=%b, required 1 1 %h %b 0",
                   i-1, v[i-1].op, v[i-1].a, v[i-1].b, out_valid_o, in_ready_o, alu_o, flags_o, err_o,
                   v[i-1].r, v[i-1].f);
        end
      end
      if (i < v.size()) drive(v[i].a, v[i].b, v[i].op);
      else idle();
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[$];
    ops.push_back(4'd12);
    ops.push_back(4'd13);
    ops.push_back(4'd14);
    ops.push_back(4'd15);
`ifndef ALU_PIPE_MUL_EN
    ops.push_back(OP_MUL);
`endif
    out_ready_i = 1'b1;
    foreach (ops[k]) begin
      drive(8'h5A, 8'hC3, ops[k]);
      @(negedge clk);
      idle();
      n_checks++;
      if ({out_valid_o, alu_o, flags_o, err_o} !== {1'b1, 8'h00, 4'b0100, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_op%0d: valid=%b alu=%h flags=%b err=%b, required 1 00 0100 1",
                 ops[k], out_valid_o, alu_o, flags_o, err_o);
      end
    end
    drive(8'h01, 8'h02, OP_ADD);
    @(negedge clk);
    idle();
    n_checks++;
    if ({out_valid_o, alu_o, err_o} !== {1'b1, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL legal_after_illegal: valid=%b alu=%h err=%b, required 1 03 0",
               out_valid_o, alu_o, err_o);
    end
  endtask

  // Scoreboard: expected results queue in acceptance order, popped as they appear.
  task automatic test_backpressure();
    logic [W-1:0] sa[4] = '{8'h10, 8'h30, 8'h0F, 8'h01};
    logic [W-1:0] sb[4] = '{8'h20, 8'h10, 8'hFF, 8'h02};
    logic [3:0]   so[4] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR};
    logic [W-1:0] sr[4] = '{8'h30, 8'h20, 8'hF0, 8'h03};
    logic [W-1:0] exp_v;
    @(negedge clk);
    out_ready_i = 1'b0;
    drive(8'h01, 8'h01, OP_ADD);
    @(negedge clk);
    drive(8'h05, 8'h05, OP_ADD);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid_o, in_ready_o, alu_o} !== {1'b1, 1'b0, 8'h02}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b ready=%b alu=%h, required 1 0 02",
                 i, out_valid_o, in_ready_o, alu_o);
      end
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_on_take: in_ready=%b, required 1", in_ready_o);
    end
    exp_q.push_back(8'h0A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_o !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_valid%0d: valid=%b queued=%0d, required 1 and a queued result",
                 i, out_valid_o, exp_q.size());
      end else begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (alu_o !== exp_v) begin
          n_fail++;
          $display("FAIL stream_order%0d: alu=%h, required %h", i, alu_o, exp_v);
        end
      end
      if (i < 4) begin
        drive(sa[i], sb[i], so[i]);
        exp_q.push_back(sr[i]);
      end else begin
        idle();
      end
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid_o, alu_o, flags_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL drain_clear: valid=%b alu=%h flags=%b err=%b, required all 0",
               out_valid_o, alu_o, flags_o, err_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    logic [W-1:0] ma[2] = '{8'h0F, 8'h10};
    logic [W-1:0] mb[2] = '{8'h11, 8'h10};
    logic [W-1:0] mr[2] = '{8'hFF, 8'h00};
    logic [3:0]   mf[2] = '{4'b1000, 4'b0110};
    out_ready_i = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive(ma[t], mb[t], OP_MUL);
      @(negedge clk);
      idle();
      n_checks++;
      if ({out_valid_o, in_ready_o, dbg_state_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL mul%0d_start: valid=%b ready=%b state=%b, required 0 0 1",
                 t, out_valid_o, in_ready_o, dbg_state_o);
      end
      for (int j = 1; j < W; j++) begin
        @(negedge clk);
        n_checks++;
        if ({out_valid_o, in_ready_o} !== 2'b00) begin
          n_fail++;
          $display("FAIL mul%0d_busy_cycle%0d: valid=%b ready=%b, required 0 0",
                   t, j, out_valid_o, in_ready_o);
        end
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid_o, alu_o, flags_o, err_o, dbg_state_o} !== {1'b1, mr[t], mf[t], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL mul%0d_result: valid=%b alu=%h flags=%b err=%b state=%b, required 1 %h %b 0 0",
                 t, out_valid_o, alu_o, flags_o, err_o, dbg_state_o, mr[t], mf[t]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_op();
    test_alu_ops();
    test_illegal();
    test_backpressure();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
